// File: rtl/pipeline_skid_stage.sv
// Elastic valid/ready pipeline register with optional two-entry skid buffer and flush.
// Latency: an entry accepted at edge N is presented after edge N; 1 entry/cycle sustained.
// Backpressure: SKID=1 gives a flop-derived o_ready (low only when two entries are held);
//               SKID=0 gives combinational o_ready = ~o_valid | i_ready.
//
// Ports:
//   i_clk, i_rstn            clock (rising edge), asynchronous active-low reset
//   i_flush                  synchronous flush: drop held entries and same-cycle input
//   i_valid/o_ready          upstream handshake, payload i_ctrl/i_data
//   o_valid/i_ready          downstream handshake, payload o_ctrl/o_data
//   o_count                  number of held entries (0..2)
module pipeline_skid_stage #(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 192,
  parameter int SKID   = 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state;
  logic              valid_q;
  logic [1:0]        count_q;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic accept;
  logic rel;

  generate
    if (SKID != 0) begin : g_skid
      // Ready depends only on the state flops, never on i_ready this cycle.
      assign o_ready = (state != ST_TWO);
    end else begin : g_noskid
      assign o_ready = ~valid_q | i_ready;
    end
  endgenerate

  assign accept = i_valid & o_ready & ~i_flush;
  assign rel    = valid_q & i_ready;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= ST_EMPTY;
      valid_q   <= 1'b0;
      count_q   <= 2'd0;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (i_flush) begin
      // Control is scrubbed so a later valid can never expose stale bits;
      // data is left as-is since it is only meaningful alongside valid.
      state     <= ST_EMPTY;
      valid_q   <= 1'b0;
      count_q   <= 2'd0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state     <= ST_ONE;
            valid_q   <= 1'b1;
            count_q   <= 2'd1;
            main_ctrl <= i_ctrl;
            main_data <= i_data;
          end
        end
        ST_ONE: begin
          if (accept && rel) begin
            main_ctrl <= i_ctrl;
            main_data <= i_data;
          end else if (accept) begin
            if (SKID != 0) begin
              // Downstream stalled: park the new entry behind the presented one.
              state     <= ST_TWO;
              count_q   <= 2'd2;
              skid_ctrl <= i_ctrl;
              skid_data <= i_data;
            end else begin
              // Unreachable without a skid buffer (accept implies release).
              main_ctrl <= i_ctrl;
              main_data <= i_data;
            end
          end else if (rel) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
            count_q <= 2'd0;
          end
        end
        ST_TWO: begin
          if (rel) begin
            state     <= ST_ONE;
            count_q   <= 2'd1;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          valid_q <= 1'b0;
          count_q <= 2'd0;
        end
      endcase
    end
  end

  assign o_valid = valid_q;
  assign o_ctrl  = main_ctrl & {CTRL_W{valid_q}};
  assign o_data  = main_data;
  assign o_count = count_q;

endmodule
